md_unit: RTL and testbench

//   Multi-cycle multiply/divide unit with HI/LO registers, in the E stage.

---
 rtl/md_unit_if.sv | 26 ++
 rtl/md_unit.sv | 167 ++++++++++++++++
 tb/tb_md_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// md_unit_if: groups the E-stage multiply/divide signals.
//   start  E-stage op valid this cycle (pipeline -> unit)
//   op     operation code: 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO
//   a, b   rs / rt operands (forwarded values)
//   busy   operation in flight (unit -> stall controller)
//   hi, lo architectural HI/LO registers (unit -> E-stage result mux)
// master = pipeline side, slave = md_unit.
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding HI/LO, E stage.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any in-flight op
//   bus      md_unit_if.slave: start/op/a/b in, busy/hi/lo out
// The full result is computed on the accept edge and parked in {phi,plo};
// busy then stays high for MULT_CYCLES / DIV_CYCLES cycles, after which the
// parked result is committed to hi/lo. MTHI/MTLO write hi/lo directly on the
// accept edge without raising busy.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  md_unit_if.slave   bus
);

  localparam int CW = 16;
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   phi_reg, phi_next;
  logic [31:0]   plo_reg, plo_next;
  logic          commit_reg, commit_next;
  logic          busy_reg, busy_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   lo_reg, lo_next;

  logic [31:0] op_a, op_b, b_safe;
  logic [63:0] prod_s, prod_u;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign op_a = bus.a;
  assign op_b = bus.b;

  // Divider never sees zero; a zero divisor is handled by suppressing the
  // commit, so the quotient computed here is simply discarded.
  assign b_safe = (op_b == 32'd0) ? 32'd1 : op_b;

  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};
  assign quo_u  = op_a / b_safe;
  assign rem_u  = op_a % b_safe;

  // Signed divide: -2^31 / -1 overflows 32 bits; define it as the wrapped
  // quotient (0x80000000) with remainder 0 so the result is deterministic.
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
      quo_s = 32'h8000_0000;
      rem_s = 32'd0;
    end else begin
      quo_s = $signed(op_a) / $signed(b_safe);
      rem_s = $signed(op_a) % $signed(b_safe);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    phi_next    = phi_reg;
    plo_next    = plo_reg;
    commit_next = commit_reg;
    busy_next   = busy_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT: begin
              {phi_next, plo_next} = prod_s;
              cnt_next    = MULT_N;
              commit_next = 1'b1;
              busy_next   = 1'b1;
              state_next  = S_RUN;
            end
            OP_MULTU: begin
              {phi_next, plo_next} = prod_u;
              cnt_next    = MULT_N;
              commit_next = 1'b1;
              busy_next   = 1'b1;
              state_next  = S_RUN;
            end
            OP_DIV: begin
              phi_next    = rem_s;
              plo_next    = quo_s;
              cnt_next    = DIV_N;
              commit_next = (op_b != 32'd0);
              busy_next   = 1'b1;
              state_next  = S_RUN;
            end
            OP_DIVU: begin
              phi_next    = rem_u;
              plo_next    = quo_u;
              cnt_next    = DIV_N;
              commit_next = (op_b != 32'd0);
              busy_next   = 1'b1;
              state_next  = S_RUN;
            end
            OP_MTHI: hi_next = op_a;
            OP_MTLO: lo_next = op_a;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // start is deliberately ignored here: a request while busy is dropped.
        if (cnt_reg == CNT_ONE) begin
          busy_next  = 1'b0;
          state_next = S_IDLE;
          if (commit_reg) begin
            hi_next = phi_reg;
            lo_next = plo_reg;
          end
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      phi_reg    <= 32'd0;
      plo_reg    <= 32'd0;
      commit_reg <= 1'b0;
      busy_reg   <= 1'b0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      phi_reg    <= phi_next;
      plo_reg    <= plo_next;
      commit_reg <= commit_next;
      busy_reg   <= busy_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized + directed bench for md_unit with a scoreboard.
// Stimulus computes each accepted op's outcome with 64-bit integer
// arithmetic and queues it; a monitor checks busy/hi/lo at the cycles the
// protocol dictates.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          cyc_done;
    int          n;
    logic [31:0] hi;
    logic [31:0] lo;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  int          op_id = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference outcome of one accepted op, from the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint p, q, r;
    nh = m_hi;
    nl = m_lo;
    n  = 0;
    case (op)
      3'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        nh = p[63:32]; nl = p[31:0]; n = MULT_N;
      end
      3'd2: begin
        p = longint'(a) * longint'(b);
        nh = p[63:32]; nl = p[31:0]; n = MULT_N;
      end
      3'd3: begin
        n = DIV_N;
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          nh = r[31:0]; nl = q[31:0];
        end
      end
      3'd4: begin
        n = DIV_N;
        if (b != 0) begin
          q = longint'(a) / longint'(b);
          r = longint'(a) % longint'(b);
          nh = r[31:0]; nl = q[31:0];
        end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endtask

  // Drive one request for the coming edge; the model decides if it is accepted.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int e, n;
    logic [31:0] nh, nl;
    exp_t ent;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    e = cyc + 1;
    if (e >= free_cyc) begin
      model(op, a, b, n, nh, nl);
      ent.cyc_done = e + n;
      ent.n  = n;
      ent.hi = nh;
      ent.lo = nl;
      ent.id = op_id;
      sb_q.push_back(ent);
      m_hi = nh;
      m_lo = nl;
      free_cyc = e + n + 1;
      $display("[TB] op#%0d accepted op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", op_id, op, a, b, nh, nl, n);
    end else begin
      $display("[TB] op#%0d ignored (busy) op=%0d a=%h b=%h", op_id, op, a, b);
    end
    op_id++;
  endtask

  // Idle cycles with start low; operands wander to prove they are not re-read.
  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
    end
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (cyc + 1 < free_cyc && budget < 100) begin
      idle(1);
      budget++;
    end
    if (budget >= 100) chk("wait_done_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: busy high at first and last busy cycle, then busy low and hi/lo.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q[0];
        if (mon_e.n > 0 && (cyc == mon_e.cyc_done - mon_e.n || cyc == mon_e.cyc_done - 1))
          chk($sformatf("busy_high op#%0d", mon_e.id), {31'd0, bus.busy}, 32'd1);
        if (cyc >= mon_e.cyc_done) begin
          chk($sformatf("busy_low op#%0d", mon_e.id), {31'd0, bus.busy}, 32'd0);
          chk($sformatf("hi op#%0d", mon_e.id), bus.hi, mon_e.hi);
          chk($sformatf("lo op#%0d", mon_e.id), bus.lo, mon_e.lo);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    idle(1);

    // 1..3: signed/unsigned multiply, signed divide, divide by zero
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);            wait_done();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);    wait_done();
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);            wait_done();
    issue(3'd4, 32'd7, 32'd0);                    wait_done();

    // 4: back-to-back MTHI / MTLO
    issue(3'd5, 32'h1234_5678, 32'd0);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0);
    idle(2);

    // 5: request during busy is dropped; operands change while busy
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd6, 32'h0000_DEAD, 32'd0);
    idle(4);
    wait_done();

    // Boundary: signed overflow divide and unsigned divide of max value
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);    wait_done();
    issue(3'd4, 32'hFFFF_FFFF, 32'd1);            wait_done();
    issue(3'd0, 32'h5555_5555, 32'd1);
    issue(3'd7, 32'hAAAA_AAAA, 32'd1);
    idle(1);

    // 6: asynchronous reset while MULT is mid-flight
    issue(3'd1, 32'd123, 32'd456);
    idle(1);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("async_rst_hi", bus.hi, 32'd0);
    chk("async_rst_lo", bus.lo, 32'd0);
    sb_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    free_cyc = 0;
    #1 reset_n = 1'b1;
    issue(3'd1, 32'hFFFF_FFFB, 32'd9);            wait_done();

    // Random traffic, including requests that land while busy
    for (int i = 0; i < 250; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 15))
        0, 1:    rb = 32'd0;
        2, 3:    rb = 32'($urandom_range(1, 16));
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) begin
        rop = 3'd3; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
      end
      issue(rop, ra, rb);
      idle($urandom_range(0, 3));
    end
    wait_done();
    idle(2);
    chk("scoreboard_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
